// File: rtl/rv_wb_arbiter_if.sv
// rtl/rv_wb_arbiter_if.sv - producer request, flush and RF write-back bundle for rv_wb_arbiter
interface rv_wb_arbiter_if #(
    parameter int WIDTH    = 32,
    parameter int NTHREADS = 4
);
    localparam int TID_W = (NTHREADS > 1) ? $clog2(NTHREADS) : 1;

    logic             alu_valid;
    logic             alu_ready;
    logic [TID_W-1:0] alu_tid;
    logic [4:0]       alu_rd;
    logic [WIDTH-1:0] alu_data;

    logic             lsu_valid;
    logic             lsu_ready;
    logic [TID_W-1:0] lsu_tid;
    logic [4:0]       lsu_rd;
    logic [WIDTH-1:0] lsu_data;

    logic             mdu_valid;
    logic             mdu_ready;
    logic [TID_W-1:0] mdu_tid;
    logic [4:0]       mdu_rd;
    logic [WIDTH-1:0] mdu_data;

    logic             flush_valid;
    logic [TID_W-1:0] flush_tid;

    logic             wb_we;
    logic [TID_W-1:0] wb_tid;
    logic [4:0]       wb_addr;
    logic [WIDTH-1:0] wb_data;
    logic [1:0]       wb_src;

    modport slave (
        input  alu_valid, alu_tid, alu_rd, alu_data,
        input  lsu_valid, lsu_tid, lsu_rd, lsu_data,
        input  mdu_valid, mdu_tid, mdu_rd, mdu_data,
        input  flush_valid, flush_tid,
        output alu_ready, lsu_ready, mdu_ready,
        output wb_we, wb_tid, wb_addr, wb_data, wb_src
    );

    modport master (
        output alu_valid, alu_tid, alu_rd, alu_data,
        output lsu_valid, lsu_tid, lsu_rd, lsu_data,
        output mdu_valid, mdu_tid, mdu_rd, mdu_data,
        output flush_valid, flush_tid,
        input  alu_ready, lsu_ready, mdu_ready,
        input  wb_we, wb_tid, wb_addr, wb_data, wb_src
    );
endinterface

// File: rtl/rv_wb_arbiter.sv
// rtl/rv_wb_arbiter.sv - round-robin arbiter for the shared RF write port (ALU, LSU, MDU)
module rv_wb_arbiter #(
    parameter int WIDTH    = 32,
    parameter int NTHREADS = 4
) (
    input  logic              clk,
    input  logic              rst,
    rv_wb_arbiter_if.slave    bus
);
    localparam int TID_W = (NTHREADS > 1) ? $clog2(NTHREADS) : 1;

    logic [2:0]       valid;
    logic [2:0]       zero_rd;
    logic [2:0]       flushed;
    logic [2:0]       drop;
    logic [2:0]       elig;
    logic [2:0]       gnt;
    logic [2:0]       cand;
    logic             gnt_any;
    logic [1:0]       gnt_idx;
    logic [1:0]       rr_ptr;
    logic [TID_W-1:0] sel_tid;
    logic [4:0]       sel_rd;
    logic [WIDTH-1:0] sel_data;

    assign valid   = {bus.mdu_valid, bus.lsu_valid, bus.alu_valid};
    assign zero_rd = {bus.mdu_rd == 5'd0, bus.lsu_rd == 5'd0, bus.alu_rd == 5'd0};
    assign flushed = {bus.flush_valid && (bus.mdu_tid == bus.flush_tid),
                      bus.flush_valid && (bus.lsu_tid == bus.flush_tid),
                      bus.flush_valid && (bus.alu_tid == bus.flush_tid)};
    // x0 writes and flushed-thread results are acknowledged but never reach the RF
    assign drop    = valid & (zero_rd | flushed);
    assign elig    = valid & ~drop;

    always_comb begin
        gnt     = 3'b000;
        gnt_any = 1'b0;
        gnt_idx = 2'd0;
        cand    = 3'd0;
        for (int k = 0; k < 3; k++) begin
            cand = {1'b0, rr_ptr} + 3'(k);
            if (cand >= 3'd3) cand = cand - 3'd3;
            if (!gnt_any && elig[cand[1:0]]) begin
                gnt[cand[1:0]] = 1'b1;
                gnt_any        = 1'b1;
                gnt_idx        = cand[1:0];
            end
        end
    end

    always_comb begin
        sel_tid  = bus.alu_tid;
        sel_rd   = bus.alu_rd;
        sel_data = bus.alu_data;
        case (gnt_idx)
            2'd1: begin
                sel_tid  = bus.lsu_tid;
                sel_rd   = bus.lsu_rd;
                sel_data = bus.lsu_data;
            end
            2'd2: begin
                sel_tid  = bus.mdu_tid;
                sel_rd   = bus.mdu_rd;
                sel_data = bus.mdu_data;
            end
            default: ;
        endcase
    end

    assign bus.alu_ready = !rst && (gnt[0] || drop[0]);
    assign bus.lsu_ready = !rst && (gnt[1] || drop[1]);
    assign bus.mdu_ready = !rst && (gnt[2] || drop[2]);

    always_ff @(posedge clk) begin
        if (rst) begin
            bus.wb_we   <= 1'b0;
            bus.wb_tid  <= '0;
            bus.wb_addr <= 5'd0;
            bus.wb_data <= '0;
            bus.wb_src  <= 2'd0;
            rr_ptr      <= 2'd0;
        end else begin
            bus.wb_we <= gnt_any;
            if (gnt_any) begin
                bus.wb_tid  <= sel_tid;
                bus.wb_addr <= sel_rd;
                bus.wb_data <= sel_data;
                bus.wb_src  <= gnt_idx;
                rr_ptr      <= (gnt_idx == 2'd2) ? 2'd0 : gnt_idx + 2'd1;
            end
        end
    end
endmodule

// File: tb/tb_rv_wb_arbiter.sv
// tb/tb_rv_wb_arbiter.sv - directed self-checking bench for rv_wb_arbiter
module tb_rv_wb_arbiter;
    logic clk = 1'b0;
    logic rst = 1'b1;
    int   n_checks = 0;
    int   n_errors = 0;

    always #5 clk = ~clk;

    rv_wb_arbiter_if #(.WIDTH(32), .NTHREADS(4)) bus ();

    rv_wb_arbiter #(.WIDTH(32), .NTHREADS(4)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic clear_all();
        bus.alu_valid = 0; bus.alu_tid = 0; bus.alu_rd = 0; bus.alu_data = 0;
        bus.lsu_valid = 0; bus.lsu_tid = 0; bus.lsu_rd = 0; bus.lsu_data = 0;
        bus.mdu_valid = 0; bus.mdu_tid = 0; bus.mdu_rd = 0; bus.mdu_data = 0;
        bus.flush_valid = 0; bus.flush_tid = 0;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        clear_all();
        rst = 1;
        tick();
        rst = 0;
        #1;
    endtask

    task automatic check_ready(input string tag, input logic [2:0] exp);
        #1;
        check({tag, ".ready"}, {61'd0, bus.mdu_ready, bus.lsu_ready, bus.alu_ready}, {61'd0, exp});
    endtask

    logic [1:0] fair_src [6] = '{2'd0, 2'd1, 2'd2, 2'd0, 2'd1, 2'd2};
    logic [2:0] fair_rdy [6] = '{3'b001, 3'b010, 3'b100, 3'b001, 3'b010, 3'b100};

    initial begin
        clear_all();

        // 1: reset with all sources requesting
        rst = 1;
        bus.alu_valid = 1; bus.alu_rd = 7;
        bus.lsu_valid = 1; bus.lsu_rd = 7;
        bus.mdu_valid = 1; bus.mdu_rd = 7;
        check_ready("rst", 3'b000);
        tick();
        check("rst.we", 64'(bus.wb_we), 64'd0);
        check("rst.addr", 64'(bus.wb_addr), 64'd0);
        check("rst.data", 64'(bus.wb_data), 64'd0);
        check("rst.src", 64'(bus.wb_src), 64'd0);
        rst = 0;
        check_ready("rst_rel", 3'b001);
        tick();
        check("rst_rel.we", 64'(bus.wb_we), 64'd1);
        check("rst_rel.src", 64'(bus.wb_src), 64'd0);

        // 2: single ALU request
        do_reset();
        bus.alu_valid = 1; bus.alu_tid = 1; bus.alu_rd = 5; bus.alu_data = 32'hDEADBEEF;
        check_ready("single", 3'b001);
        tick();
        clear_all();
        check("single.we", 64'(bus.wb_we), 64'd1);
        check("single.tid", 64'(bus.wb_tid), 64'd1);
        check("single.addr", 64'(bus.wb_addr), 64'd5);
        check("single.data", 64'(bus.wb_data), 64'hDEADBEEF);
        check("single.src", 64'(bus.wb_src), 64'd0);
        tick();
        check("idle.we", 64'(bus.wb_we), 64'd0);
        check("idle.addr_hold", 64'(bus.wb_addr), 64'd5);
        check("idle.data_hold", 64'(bus.wb_data), 64'hDEADBEEF);

        // 3: fairness with all three continuously valid
        do_reset();
        bus.alu_valid = 1; bus.alu_rd = 1; bus.alu_data = 32'hA;
        bus.lsu_valid = 1; bus.lsu_rd = 2; bus.lsu_data = 32'hB;
        bus.mdu_valid = 1; bus.mdu_rd = 3; bus.mdu_data = 32'hC;
        for (int c = 0; c < 6; c++) begin
            check_ready($sformatf("fair%0d", c), fair_rdy[c]);
            tick();
            check($sformatf("fair%0d.we", c), 64'(bus.wb_we), 64'd1);
            check($sformatf("fair%0d.src", c), 64'(bus.wb_src), 64'(fair_src[c]));
            check($sformatf("fair%0d.addr", c), 64'(bus.wb_addr), 64'(fair_src[c]) + 64'd1);
        end

        // 4: x0 drop alongside a grant; drop must not advance rr_ptr
        do_reset();
        bus.alu_valid = 1; bus.alu_rd = 3; bus.alu_data = 32'h33;
        bus.lsu_valid = 1; bus.lsu_rd = 0; bus.lsu_data = 32'h99;
        check_ready("x0", 3'b011);
        tick();
        check("x0.we", 64'(bus.wb_we), 64'd1);
        check("x0.addr", 64'(bus.wb_addr), 64'd3);
        check("x0.data", 64'(bus.wb_data), 64'h33);
        bus.lsu_rd = 4;
        bus.mdu_valid = 1; bus.mdu_rd = 6;
        check_ready("x0.ptr", 3'b010);
        tick();
        check("x0.ptr.src", 64'(bus.wb_src), 64'd1);

        // 5: flush drops thread 2, ALU on thread 0 is granted
        do_reset();
        bus.flush_valid = 1; bus.flush_tid = 2;
        bus.mdu_valid = 1; bus.mdu_tid = 2; bus.mdu_rd = 9; bus.mdu_data = 32'h9;
        bus.alu_valid = 1; bus.alu_tid = 0; bus.alu_rd = 4; bus.alu_data = 32'h4;
        check_ready("flush", 3'b101);
        tick();
        check("flush.addr", 64'(bus.wb_addr), 64'd4);
        check("flush.src", 64'(bus.wb_src), 64'd0);
        check("flush.tid", 64'(bus.wb_tid), 64'd0);
        // every valid source flushed: no grant
        clear_all();
        bus.flush_valid = 1; bus.flush_tid = 2;
        bus.alu_valid = 1; bus.alu_tid = 2; bus.alu_rd = 1;
        bus.lsu_valid = 1; bus.lsu_tid = 2; bus.lsu_rd = 2;
        check_ready("flush_all", 3'b011);
        tick();
        check("flush_all.we", 64'(bus.wb_we), 64'd0);
        // flush acts only in its own cycle
        clear_all();
        bus.mdu_valid = 1; bus.mdu_tid = 2; bus.mdu_rd = 9; bus.mdu_data = 32'h99;
        check_ready("post_flush", 3'b100);
        tick();
        check("post_flush.we", 64'(bus.wb_we), 64'd1);
        check("post_flush.addr", 64'(bus.wb_addr), 64'd9);

        // 6: reset while a write is pending in the wb register
        do_reset();
        bus.alu_valid = 1; bus.alu_rd = 6; bus.alu_data = 32'h66;
        bus.lsu_valid = 1; bus.lsu_rd = 7; bus.lsu_data = 32'h77;
        check_ready("midrst.pre", 3'b001);
        tick();
        check("midrst.pending", 64'(bus.wb_we), 64'd1);
        bus.alu_rd = 8; bus.alu_data = 32'h88;
        rst = 1;
        check_ready("midrst", 3'b000);
        tick();
        check("midrst.we", 64'(bus.wb_we), 64'd0);
        check("midrst.addr", 64'(bus.wb_addr), 64'd0);
        rst = 0;
        check_ready("midrst.rel", 3'b001);
        tick();
        check("midrst.rel.src", 64'(bus.wb_src), 64'd0);
        check("midrst.rel.addr", 64'(bus.wb_addr), 64'd8);
        bus.alu_valid = 0;
        check_ready("midrst.held", 3'b010);
        tick();
        check("midrst.held.src", 64'(bus.wb_src), 64'd1);
        check("midrst.held.data", 64'(bus.wb_data), 64'h77);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end
endmodule
